// File: rtl/display_pkg.sv
// Shared constants, types and helpers for the display controller.
package display_pkg;

  // Active-low segments: all ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // LIVE shows the selected bus/register, VIEW browses the capture history.
  typedef enum logic {
    LIVE,
    VIEW
  } mode_t;

  // Number of hex digits needed to show a value of the given width.
  function automatic int unsigned ndig(input int unsigned data_w);
    return (data_w + 3) / 4;
  endfunction

endpackage

// File: rtl/disp_history.sv
// Capture history ring buffer: write at wr_ptr, read relative to the newest entry.
module disp_history #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_offset,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);

  logic [AW-1:0]     wr_ptr_q;
  logic [AW:0]       count_q;
  logic [AW-1:0]     rd_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // Write pointer wraps naturally (DEPTH is a power of two); count saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (count_q != FULL) begin
        count_q <= count_q + CNT_ONE;
      end
    end
  end

  // Storage is never cleared; count=0 keeps stale contents from being shown.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Offset 0 addresses the most recently written entry.
  always_comb begin
    rd_idx  = wr_ptr_q - PTR_ONE - rd_offset;
    rd_data = mem[rd_idx];
    count   = count_q;
  end

endmodule

// File: rtl/seven_seg.sv
// Hex nibble to active-low seven-segment glyph, segment order {g,f,e,d,c,b,a}.
module seven_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Glyph lookup for all sixteen hex values.
  always_comb begin
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b0000011;
      4'hc: seg = 7'b1000110;
      4'hd: seg = 7'b0100001;
      4'he: seg = 7'b0000110;
      4'hf: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/display_ctrl.sv
// Front-panel display controller: live bus/register view, capture history browser,
// timestep digit and a pulse-stretched done LED.
module display_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STRETCH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         BUS,
  input  logic [DATA_W-1:0]         REG,
  input  logic [1:0]                TIME,
  input  logic                      PEEKb,
  input  logic                      DONE,
  input  logic                      CAPTURE,
  input  logic                      FREEZE,
  input  logic                      STEPb,
  output logic [DATA_W-1:0]         LEDB,
  output logic [6:0]                THEX,
  output logic [7*ndig(DATA_W)-1:0] DHEX,
  output logic [6:0]                IHEX,
  output logic                      LED_DONE
);

  localparam int unsigned NDIG = ndig(DATA_W);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned SW   = $clog2(STRETCH + 1);

  localparam logic [AW-1:0] OFF_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [SW-1:0] STRETCH_LD = SW'(STRETCH);
  localparam logic [SW-1:0] STR_ONE    = SW'(1);

  // Registered state
  mode_t              mode_q;
  logic               step_q;
  logic [AW-1:0]      offset_q;
  logic [SW-1:0]      stretch_q;
  logic [7*NDIG-1:0]  dhex_q;
  logic [6:0]         ihex_q;
  logic               led_done_q;

  // Next-state and datapath
  mode_t              mode_d;
  logic [AW-1:0]      offset_d;
  logic [SW-1:0]      stretch_d;
  logic               led_done_d;
  logic               step_fall;
  logic [DATA_W-1:0]  src;
  logic [4*NDIG-1:0]  data_pad;
  logic [7*NDIG-1:0]  glyph_all;
  logic [7*NDIG-1:0]  dhex_d;
  logic [AW+3:0]      off_ext;
  logic [6:0]         ihex_glyph;
  logic [6:0]         ihex_d;
  logic [DATA_W-1:0]  hist_data;
  logic [AW:0]        hist_count;

  disp_history #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_history (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (CAPTURE & ~FREEZE),
    .wr_data   (BUS),
    .rd_offset (offset_d),
    .rd_data   (hist_data),
    .count     (hist_count)
  );

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    seven_seg u_seg (
      .hex (data_pad[4*g +: 4]),
      .seg (glyph_all[7*g +: 7])
    );
  end

  seven_seg u_thex (
    .hex ({2'b00, TIME}),
    .seg (THEX)
  );

  seven_seg u_ihex (
    .hex (off_ext[3:0]),
    .seg (ihex_glyph)
  );

  // Mode, view offset and done-stretch next state.
  always_comb begin
    mode_d     = FREEZE ? VIEW : LIVE;
    step_fall  = step_q & ~STEPb;
    offset_d   = offset_q;
    stretch_d  = stretch_q;
    led_done_d = 1'b1;

    if (!FREEZE || mode_q == LIVE) begin
      // Entering VIEW always starts at the newest entry.
      offset_d = '0;
    end else if (step_fall && hist_count != '0) begin
      offset_d = (({1'b0, offset_q} + CNT_ONE) == hist_count) ? '0 : offset_q + OFF_ONE;
    end

    if (DONE) begin
      stretch_d  = STRETCH_LD;
      led_done_d = 1'b0;
    end else if (stretch_q != '0) begin
      stretch_d  = stretch_q - STR_ONE;
      led_done_d = 1'b0;
    end
  end

  // Displayed value and glyph selection for the registered outputs.
  always_comb begin
    src      = FREEZE ? hist_data : (PEEKb ? BUS : REG);
    data_pad = '0;
    data_pad[DATA_W-1:0] = src;
    off_ext  = {4'b0000, offset_d};
    dhex_d   = (FREEZE && hist_count == '0) ? {NDIG{SEG_BLANK}} : glyph_all;
    ihex_d   = FREEZE ? ihex_glyph : SEG_BLANK;
  end

  // All state and registered outputs; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= LIVE;
      step_q     <= 1'b1;
      offset_q   <= '0;
      stretch_q  <= '0;
      dhex_q     <= {NDIG{SEG_BLANK}};
      ihex_q     <= SEG_BLANK;
      led_done_q <= 1'b1;
    end else begin
      mode_q     <= mode_d;
      step_q     <= STEPb;
      offset_q   <= offset_d;
      stretch_q  <= stretch_d;
      dhex_q     <= dhex_d;
      ihex_q     <= ihex_d;
      led_done_q <= led_done_d;
    end
  end

  assign LEDB     = BUS;
  assign DHEX     = dhex_q;
  assign IHEX     = ihex_q;
  assign LED_DONE = led_done_q;

endmodule

// File: tb/tb_display_ctrl.sv
// Randomised and directed checks of display_ctrl against a queue-based reference model.
module tb_display_ctrl;

  logic        clk = 1'b0;
  logic        reset, PEEKb, DONE, CAPTURE, FREEZE, STEPb;
  logic [9:0]  BUS, REG;
  logic [1:0]  TIME;
  logic [9:0]  LEDB;
  logic [6:0]  THEX, IHEX;
  logic [20:0] DHEX;
  logic        LED_DONE;

  always #5 clk = ~clk;

  display_ctrl #(
    .DATA_W  (10),
    .DEPTH   (8),
    .STRETCH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .BUS      (BUS),
    .REG      (REG),
    .TIME     (TIME),
    .PEEKb    (PEEKb),
    .DONE     (DONE),
    .CAPTURE  (CAPTURE),
    .FREEZE   (FREEZE),
    .STEPb    (STEPb),
    .LEDB     (LEDB),
    .THEX     (THEX),
    .DHEX     (DHEX),
    .IHEX     (IHEX),
    .LED_DONE (LED_DONE)
  );

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0]  BLANK  = 7'b1111111;
  localparam logic [20:0] BLANK3 = {3{7'b1111111}};

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [9:0]  hist [$];
  int          offset;
  bit          prev_freeze;
  bit          step_prev;
  int          cyc = 0;
  int          last_done = -1000;
  logic [20:0] exp_dhex;
  logic [6:0]  exp_ihex;
  logic        exp_led;

  function automatic logic [20:0] digits(input logic [9:0] v);
    logic [11:0] p;
    logic [20:0] r;
    p = {2'b00, v};
    for (int i = 0; i < 3; i++) r[7*i +: 7] = glyph[p[4*i +: 4]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model over one clock edge, then compare every output.
  task automatic tick();
    cyc++;
    if (reset) begin
      hist.delete();
      offset      = 0;
      prev_freeze = 1'b0;
      step_prev   = 1'b1;
      last_done   = -1000;
      exp_dhex    = BLANK3;
      exp_ihex    = BLANK;
      exp_led     = 1'b1;
    end else begin
      if (CAPTURE && !FREEZE) begin
        hist.push_back(BUS);
        if (hist.size() > 8) void'(hist.pop_front());
      end
      if (FREEZE) begin
        if (!prev_freeze) offset = 0;
        else if (step_prev && !STEPb && hist.size() > 0) offset = (offset + 1) % hist.size();
        exp_dhex = (hist.size() == 0) ? BLANK3 : digits(hist[hist.size() - 1 - offset]);
        exp_ihex = glyph[offset];
      end else begin
        exp_dhex = digits(PEEKb ? BUS : REG);
        exp_ihex = BLANK;
      end
      if (DONE) begin
        last_done = cyc;
        exp_led   = 1'b0;
      end else begin
        exp_led = !((cyc - last_done) <= 4);
      end
      prev_freeze = FREEZE;
      step_prev   = STEPb;
    end
    @(posedge clk);
    #1;
    check("dhex", 32'(DHEX), 32'(exp_dhex));
    check("ihex", 32'(IHEX), 32'(exp_ihex));
    check("led_done", 32'(LED_DONE), 32'(exp_led));
    check("ledb", 32'(LEDB), 32'(BUS));
    check("thex", 32'(THEX), 32'(glyph[{2'b00, TIME}]));
  endtask

  task automatic press();
    STEPb = 1'b0;
    tick();
    STEPb = 1'b1;
    tick();
  endtask

  int lows;

  initial begin
    reset = 1'b1; PEEKb = 1'b1; DONE = 1'b0; CAPTURE = 1'b0; FREEZE = 1'b0; STEPb = 1'b1;
    BUS = '0; REG = '0; TIME = 2'd0;
    tick();
    check("reset_dhex", 32'(DHEX), 32'(BLANK3));
    check("reset_ihex", 32'(IHEX), 32'(BLANK));
    check("reset_led", 32'(LED_DONE), 32'd1);

    // Live bus then live register
    reset = 1'b0; BUS = 10'h2a5; TIME = 2'd3;
    tick();
    check("live_bus", 32'(DHEX), 32'({glyph[2], glyph[10], glyph[5]}));
    PEEKb = 1'b0; REG = 10'h3ff;
    tick();
    check("live_reg", 32'(DHEX), 32'({glyph[3], glyph[15], glyph[15]}));
    check("ledb_bus", 32'(LEDB), 32'h2a5);

    // View with empty history; captures ignored
    FREEZE = 1'b1;
    tick();
    check("empty_view", 32'(DHEX), 32'(BLANK3));
    check("empty_ihex", 32'(IHEX), 32'(glyph[0]));
    CAPTURE = 1'b1; BUS = 10'h155;
    tick();
    tick();
    CAPTURE = 1'b0;
    tick();
    check("frozen_capture", 32'(DHEX), 32'(BLANK3));

    // Capture 1..10, browse history
    FREEZE = 1'b0; PEEKb = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      CAPTURE = 1'b1; BUS = 10'(i);
      tick();
    end
    CAPTURE = 1'b0; FREEZE = 1'b1;
    tick();
    check("view_newest", 32'(DHEX), 32'(digits(10'd10)));
    check("view_off0", 32'(IHEX), 32'(glyph[0]));
    for (int i = 0; i < 7; i++) press();
    check("view_step7", 32'(DHEX), 32'(digits(10'd3)));
    check("view_off7", 32'(IHEX), 32'(glyph[7]));
    press();
    check("view_wrap", 32'(DHEX), 32'(digits(10'd10)));
    check("view_wrap_off", 32'(IHEX), 32'(glyph[0]));

    // Held-low step only advances once
    STEPb = 1'b0;
    repeat (4) tick();
    STEPb = 1'b1;
    tick();
    check("held_step", 32'(IHEX), 32'(glyph[1]));

    // Reset while viewing at offset 5
    repeat (4) press();
    check("pre_reset_off", 32'(IHEX), 32'(glyph[5]));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_blank", 32'(DHEX), 32'(BLANK3));
    check("post_reset_ihex", 32'(IHEX), 32'(glyph[0]));

    // Done stretch: 3 cycles high gives 7 low cycles
    FREEZE = 1'b0;
    tick();
    lows = 0;
    DONE = 1'b1;
    repeat (3) begin
      tick();
      if (LED_DONE == 1'b0) lows++;
    end
    DONE = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (LED_DONE == 1'b1) break;
      lows++;
    end
    check("stretch_len", 32'(lows), 32'd7);

    // Re-pulse at stretch cycle 2 reloads the stretch
    DONE = 1'b1;
    repeat (3) tick();
    DONE = 1'b0;
    repeat (2) tick();
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (LED_DONE == 1'b1) break;
      lows++;
    end
    check("stretch_reload", 32'(lows), 32'd4);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) FREEZE = ~FREEZE;
      CAPTURE = ($urandom_range(0, 2) == 0);
      STEPb   = 1'($urandom_range(0, 1));
      DONE    = ($urandom_range(0, 7) == 0);
      PEEKb   = 1'($urandom_range(0, 1));
      BUS     = 10'($urandom);
      REG     = 10'($urandom);
      TIME    = 2'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_ctrl.md
DISPLAY_CTRL -- requirements
Module: display_ctrl

Interface
REQ-001 Parameter DATA_W, default 10: width of bus/register values displayed.
REQ-002 Parameter DEPTH, default 8 (power of 2, >=2): history buffer entries.
REQ-003 Parameter STRETCH, default 4 (>=1): cycles LED_DONE stays lit after DONE falls.
REQ-004 Derived NDIG = ceil(DATA_W/4): number of data hex digits.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 BUS  in  DATA_W  data bus value.
REQ-008 REG  in  DATA_W  register-file second read port.
REQ-009 TIME  in  2  current timestep.
REQ-010 PEEKb  in  1  live source select: 1 = BUS, 0 = REG.
REQ-011 DONE  in  1  instruction-complete level.
REQ-012 CAPTURE  in  1  one-cycle strobe: record BUS into history.
REQ-013 FREEZE  in  1  level: 1 = VIEW mode (history), 0 = LIVE mode.
REQ-014 STEPb  in  1  active-low step button, already synchronised and debounced.
REQ-015 LEDB  out  DATA_W  equals BUS, combinational.
REQ-016 THEX  out  7  seven-seg of {2'b00,TIME}, combinational.
REQ-017 DHEX  out  NDIG x 7  data digits, digit 0 = bits [3:0]; top digit zero-extended.
REQ-018 IHEX  out  7  seven-seg of current view offset (VIEW) or blank (LIVE).
REQ-019 LED_DONE  out  1  active-low done indicator.

Function
REQ-020 Modes LIVE and VIEW; mode = FREEZE sampled each cycle; no other states.
REQ-021 LIVE: DHEX registered, shows BUS if PEEKb=1 else REG, 1-cycle latency.
REQ-022 History ring: CAPTURE=1 and FREEZE=0 writes BUS at wr_ptr, wr_ptr+1 mod DEPTH, count saturates at DEPTH.
REQ-023 CAPTURE while FREEZE=1 is ignored (no write, no pointer/count change).
REQ-024 LIVE->VIEW transition (FREEZE 0->1) resets view offset to 0 (newest entry).
REQ-025 VIEW: DHEX registered, shows entry (wr_ptr-1-offset) mod DEPTH, 1-cycle latency.
REQ-026 STEPb falling edge (1->0 across consecutive cycles) in VIEW: offset+1; offset = count-1 wraps to 0.
REQ-027 STEPb edges in LIVE are ignored; held-low STEPb steps once only.
REQ-028 VIEW with count=0: all DHEX digits blank (7'b1111111), IHEX shows 0.
REQ-029 IHEX registered alongside DHEX; blank in LIVE.
REQ-030 LED_DONE=0 while DONE=1, and for exactly STRETCH cycles after DONE falls; else 1.
REQ-031 DONE rising during a stretch reloads the counter; stretch counter saturates, never wraps.
REQ-032 Glyph encoding identical to the existing seven_seg decoder.

Reset
REQ-033 reset: wr_ptr=0, count=0, offset=0, stretch counter=0, step-edge history=1.
REQ-034 Registered outputs after reset: DHEX all blank, IHEX blank, LED_DONE=1.
REQ-035 History storage contents need not be cleared; count=0 guarantees it is never shown.
REQ-036 reset mid-capture or mid-stretch wins over all other events that cycle.

Structure
REQ-037 Package display_pkg: SEG_BLANK constant, mode enum {LIVE,VIEW}, NDIG function.
REQ-038 Sub-module disp_history: ring buffer (wr_ptr, count, read by offset); display_ctrl instantiates it plus seven_seg per digit.

Verification
REQ-039 reset, FREEZE=0, PEEKb=1, BUS=10'h2A5 -> next cycle DHEX = 5,A,2; LED_DONE=1; IHEX blank.
REQ-040 PEEKb=0, REG=10'h3FF -> DHEX = F,F,3 one cycle later; LEDB still equals BUS.
REQ-041 Capture 10 values 1..10 (DEPTH=8), FREEZE=1 -> DHEX shows 10, IHEX 0; 7 STEPb presses -> 3; 8th press -> 10, IHEX 0.
REQ-042 FREEZE=1 with no captures since reset -> DHEX blank, IHEX 0; CAPTURE pulses ignored, still blank.
REQ-043 DONE high 3 cycles then low, STRETCH=4 -> LED_DONE low exactly 7 cycles; DONE re-pulse at stretch cycle 2 -> reloads, low 4 cycles after its fall.
REQ-044 reset asserted while in VIEW with offset 5 -> next cycle DHEX blank, count 0, mode follows FREEZE.
